fp_mult_sched: RTL and testbench
================================

// Module: fp_mult_sched
// PURPOSE
//  Round-robin scheduler sharing one FP16 multiplier (E=7, M=8, bias 63) among N requesters.
//  Accepts one operand pair at a time, drives the shared multiplier, and waits LAT cycles.
//  Returns result + encoded status to the issuing requester. Sits between CPU-side
//  peripherals / accelerators and the single multiplier instance.
// PARAMETERS
//  N    4   number of requesters (>=2)
//  LAT  3   cycles from operand drive to multiplier result valid (>=1)
//  W    16  FP word width (must equal 1+E+M of the multiplier)
// PORTS
//  clk            in   1     single system clock
//  reset          in   1     asynchronous, active-high reset
//  req_valid      in   N     requester i has an operand pair pending
//  req_ready      out  N     one-hot accept; transfer when req_valid[i]&req_ready[i]
//  req_op1        in   N*W   operand X, requester i at [i*W +: W]
//  req_op2        in   N*W   operand Y, same packing
//  rsp_valid      out  N     one-hot, one-cycle result strobe to requester i
//  rsp_result     out  W     product, valid while any rsp_valid bit is high
//  rsp_status     out  3     0 ok, 1 overflow, 2 underflow, 3 zero, 4 nan
//  rsp_id         out  IDW   index of responding requester, IDW=max(1,$clog2(N))
//  mul_x, mul_y   out  W     operands to shared multiplier, held stable during an op
//  mul_result     in   W     multiplier product
//  mul_nan/mul_overflow/mul_underflow/mul_zero  in 1 each  multiplier flags
//  busy           out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, cnt=0. All outputs 0 (req_ready, rsp_valid, rsp_result,
//   rsp_status, rsp_id, mul_x, mul_y, busy). Reset mid-op aborts it; no response is issued.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: grant g = first i with req_valid[i], searching ptr, ptr+1, ... mod N.
//   req_ready = onehot(g) combinationally; zero when no request or not IDLE.
//   On accept edge: mul_x/mul_y <= req_op1/op2[g], id <= g, cnt <= LAT,
//   ptr <= (g+1) mod N, state <= WAIT.
//  WAIT: cnt decrements each edge. At the edge where cnt==1, capture:
//   rsp_result <= mul_result; rsp_status <= nan?4 : zero?3 : underflow?2 : overflow?1 : 0.
//   Then state <= RESP.
//  RESP: rsp_valid = onehot(id) for exactly one cycle, then IDLE.
//  Latency: accept edge at cycle t -> rsp_valid high in cycle t+LAT.
//   Next accept no earlier than cycle t+LAT+1. Throughput 1 op / (LAT+2) cycles.
//  mul_x/mul_y keep their last value after the op (not cleared).
//  rsp_result/rsp_status/rsp_id hold their last captured value between responses.
//  Requester must hold req_valid and operands until accepted. A requester may keep
//   req_valid high during its own WAIT/RESP; it is re-eligible only after the others in
//   rr order (no starvation; worst-case wait (N-1)*(LAT+2) cycles).
//  N not a power of 2: ptr wraps N-1 -> 0 explicitly.
//  req_valid changes while not IDLE are ignored.
// CONFIGURATION
//  FP_SCHED_FIXED_PRI_EN defined: g = lowest index with req_valid set; ptr is not
//   updated (starvation allowed).
//  Undefined (default): round-robin as above.
// STRUCTURE
//  Package fp_mult_pkg: FP16 constants (E=7, M=8, EB=63, MAXEXP=127).
//   Status enum fp_status_e {ST_OK=0, ST_OVF=1, ST_UNF=2, ST_ZERO=3, ST_NAN=4}.
//   FSM enum sched_state_e.
//  Sub-module rr_grant #(N): req vector + ptr -> one-hot grant + index.
//   Holds the FP_SCHED_FIXED_PRI_EN alternative.
// TESTING (bench models multiplier with LAT-cycle delay; N=4, LAT=3)
//  1 Req0 op 0x3F00*0x4000 (1.0*2.0): accept at t -> rsp_valid=0001 at t+3,
//    result 0x4000, status 0, id 0.
//  2 Req1,2,3 all valid at t: accept order 1,2,3, one response each.
//    Accepts at t, t+5, t+10.
//  3 Req2 0x3F80*0x3F80 -> 0x4020 status 0. Req0 0x7F01*0x3F00 -> status 4.
//    Req3 0x0000*0x4000 -> 0x0000, status 3.
//  4 All four valid continuously for 20 ops: each index served 5 times in rotation 0,1,2,3.
//  5 Reset asserted in WAIT (cnt=2): outputs 0 immediately; no rsp_valid ever for that op.
//    After release, req0 accepted on the first IDLE cycle.
//  6 FP_SCHED_FIXED_PRI_EN defined, req0 and req3 held valid: req0 served every
//    time, req3 never.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared definitions for the FP16 multiplier scheduler.
// FP16 format: 1 sign, 7 exponent, 8 mantissa bits, exponent bias 63.
// Holds the format constants, the response status encoding, the scheduler
// FSM state type and a helper that folds multiplier flags into a status code.
package fp_mult_pkg;

  localparam int unsigned FP_E      = 7;
  localparam int unsigned FP_M      = 8;
  localparam int unsigned FP_EB     = 63;
  localparam int unsigned FP_MAXEXP = 127;

  typedef enum logic [2:0] {
    ST_OK   = 3'd0,
    ST_OVF  = 3'd1,
    ST_UNF  = 3'd2,
    ST_ZERO = 3'd3,
    ST_NAN  = 3'd4
  } fp_status_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } sched_state_e;

  // NaN dominates, then zero, underflow and overflow.
  function automatic fp_status_e fp_status_encode(input logic nan, input logic zero,
                                                  input logic underflow,
                                                  input logic overflow);
    if (nan)            return ST_NAN;
    else if (zero)      return ST_ZERO;
    else if (underflow) return ST_UNF;
    else if (overflow)  return ST_OVF;
    else                return ST_OK;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant: picks one requester from a request vector.
// Default: round-robin search starting at ptr_i and wrapping N-1 -> 0.
// With FP_SCHED_FIXED_PRI_EN defined: lowest set index wins, ptr_i is ignored.
// Ports:
//   req_i        N    request vector
//   ptr_i        IDW  index searched first (round-robin only)
//   grant_o      N    one-hot grant, zero when no request
//   grant_idx_o  IDW  index of the granted requester
//   grant_any_o  1    some request is present
module rr_grant #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] grant_idx_o,
  output logic           grant_any_o
);

`ifdef FP_SCHED_FIXED_PRI_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (!grant_any_o && req_i[k]) begin
        grant_o[k]  = 1'b1;
        grant_idx_o = IDW'(k);
        grant_any_o = 1'b1;
      end
    end
  end
`else
  int unsigned idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap so non-power-of-two N never indexes past N-1.
      idx = 32'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_any_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDW'(idx);
        grant_any_o  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fp_mult_sched.sv
// fp_mult_sched: shares one FP16 multiplier (E=7, M=8, bias 63) among N requesters.
// One operand pair is accepted at a time, held on mul_x/mul_y for LAT cycles, and the
// captured product and status are returned to the issuing requester.
// Config macro: FP_SCHED_FIXED_PRI_EN (fixed lowest-index priority instead of round-robin).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   N-bit request handshake, req_ready one-hot
//   req_op1/req_op2       N*W packed operands, requester i at [i*W +: W]
//   rsp_valid             N-bit one-hot, one-cycle result strobe
//   rsp_result/status/id  product, status code (fp_status_e), responder index
//   mul_x/mul_y           operands to the shared multiplier
//   mul_result + flags    multiplier product and nan/overflow/underflow/zero flags
//   busy                  high whenever not idle
module fp_mult_sched
  import fp_mult_pkg::*;
#(
  parameter  int unsigned N   = 4,
  parameter  int unsigned LAT = 3,
  parameter  int unsigned W   = 16,
  localparam int unsigned IDW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_op1,
  input  logic [N*W-1:0] req_op2,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_result,
  output logic [2:0]     rsp_status,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   mul_x,
  output logic [W-1:0]   mul_y,
  input  logic [W-1:0]   mul_result,
  input  logic           mul_nan,
  input  logic           mul_overflow,
  input  logic           mul_underflow,
  input  logic           mul_zero,
  output logic           busy
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT + 1) : 1;

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic           accept;

  rr_grant #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_grant (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != StIdle);
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so every output reads zero while reset is held.
        if (!reset) req_ready = grant;
        accept = grant_any && !reset;
        if (accept) state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CW'(1)) state_d = StResp;
      end
      StResp: begin
        rsp_valid = {{(N-1){1'b0}}, 1'b1} << rsp_id;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef FP_SCHED_FIXED_PRI_EN
  assign ptr_d = ptr_q;
`else
  assign ptr_d = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
      mul_x      <= '0;
      mul_y      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mul_x  <= req_op1[grant_idx*W +: W];
        mul_y  <= req_op2[grant_idx*W +: W];
        rsp_id <= grant_idx;
        cnt_q  <= CW'(LAT);
        ptr_q  <= ptr_d;
      end
      if (state_q == StWait) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          rsp_result <= mul_result;
          rsp_status <= fp_status_encode(mul_nan, mul_zero, mul_underflow, mul_overflow);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_sched.sv
module tb_fp_mult_sched;
  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int W   = 16;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_op1, req_op2;
  logic [W-1:0]   rsp_result, mul_x, mul_y, mul_result;
  logic [2:0]     rsp_status;
  logic [IDW-1:0] rsp_id;
  logic           mul_nan, mul_overflow, mul_underflow, mul_zero, busy;

  always #5 clk = ~clk;

  fp_mult_sched #(.N(N), .LAT(LAT), .W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_status    (rsp_status),
    .rsp_id        (rsp_id),
    .mul_x         (mul_x),
    .mul_y         (mul_y),
    .mul_result    (mul_result),
    .mul_nan       (mul_nan),
    .mul_overflow  (mul_overflow),
    .mul_underflow (mul_underflow),
    .mul_zero      (mul_zero),
    .busy          (busy)
  );

  // Multiplier model: returns {nan, ovf, unf, zero, result}.
  function automatic logic [19:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [6:0]  ea, eb;
    logic [7:0]  ma, mb, m;
    logic [17:0] p;
    int          e;
    s  = a[15] ^ b[15];
    ea = a[14:8]; eb = b[14:8];
    ma = a[7:0];  mb = b[7:0];
    if ((ea == 7'd127 && ma != 0) || (eb == 7'd127 && mb != 0)) return {4'b1000, 16'h7FFF};
    if (ea == 0 || eb == 0) return {4'b0001, s, 15'h0};
    e = int'(ea) + int'(eb) - 63;
    p = {10'b0, 1'b1, ma} * {10'b0, 1'b1, mb};
    if (p[17]) begin
      m = p[16:9];
      e = e + 1;
    end else begin
      m = p[15:8];
    end
    if (e >= 127) return {4'b0100, s, 7'h7F, 8'h00};
    if (e <= 0) return {4'b0010, s, 15'h0};
    return {4'b0000, s, e[6:0], m};
  endfunction

  // LAT-1 register stages: product is ready before the capture edge, stale before that.
  logic [19:0] pipe0 = '0, pipe1 = '0;
  always @(posedge clk) begin
    pipe0 <= fp_mul(mul_x, mul_y);
    pipe1 <= pipe0;
  end
  assign {mul_nan, mul_overflow, mul_underflow, mul_zero, mul_result} = pipe1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    res;
    logic [2:0]     st;
    int             cyc;
  } exp_t;

  exp_t sb_q[$];
  int   ord_q[$];
  int   n_tests = 0, n_fail = 0;

  int          rem [N];
  logic [15:0] op1 [N], op2 [N], xres [N];
  logic [2:0]  xst [N];
  logic [N-1:0] last_acc;
  bit          gap_chk;
  int          prev_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each response strobe.
  always @(negedge clk) begin
    if (rsp_valid != 0) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid %b with nothing outstanding", rsp_valid);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_valid",   64'(rsp_valid), 64'(4'b0001 << e.id));
        check("rsp_id",      64'(rsp_id), 64'(e.id));
        check("rsp_result",  64'(rsp_result), 64'(e.res));
        check("rsp_status",  64'(rsp_status), 64'(e.st));
        check("rsp_latency", 64'(cyc - e.cyc), 64'(LAT));
      end
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic [2:0] s, input int count);
    op1[i] = a; op2[i] = b; xres[i] = r; xst[i] = s; rem[i] = count;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (rem[i] > 0);
      req_op1[i*W +: W]  = op1[i];
      req_op2[i*W +: W]  = op2[i];
    end
  endtask

  task automatic advance();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (last_acc[i]) rem[i] = rem[i] - 1;
    last_acc = '0;
    drive();
  endtask

  task automatic sample();
    logic [N-1:0] acc;
    int g;
    exp_t e;
    #1;
    acc = req_valid & req_ready;
    if (acc != 0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (acc[i]) g = i;
      check("ready_onehot", 64'($countones(acc)), 64'd1);
      e.id = g[IDW-1:0]; e.res = xres[g]; e.st = xst[g]; e.cyc = cyc + 1;
      sb_q.push_back(e);
      if (ord_q.size() != 0) check("grant_order", 64'(g), 64'(ord_q.pop_front()));
      if (gap_chk && prev_acc >= 0) check("accept_gap", 64'(cyc + 1 - prev_acc), 64'(LAT + 2));
      prev_acc = cyc + 1;
      last_acc = acc;
    end
  endtask

  task automatic step();
    advance();
    sample();
  endtask

  function automatic int rem_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i];
    return s;
  endfunction

  task automatic drain(input string name);
    int k = 0;
    while ((rem_sum() != 0 || sb_q.size() != 0 || last_acc != 0) && k < 400) begin
      step();
      k++;
    end
    if (k >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d ops still outstanding", name, sb_q.size() + rem_sum());
    end
    if (ord_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_grants: %0d expected grants never seen", name, ord_q.size());
      ord_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; req_op1 = '0; req_op2 = '0;
    last_acc = '0; gap_chk = 0; prev_acc = -1;
    for (int i = 0; i < N; i++) set_req(i, 16'h0, 16'h0, 16'h0, 3'd0, 0);

    repeat (2) @(negedge clk);
    #1 check("reset_outputs",
             64'({req_ready, rsp_valid, rsp_result, rsp_status, rsp_id, mul_x, mul_y, busy}),
             64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("idle_not_busy", 64'(busy), 64'd0);

    // Test 1: 1.0 * 2.0 from requester 0.
    set_req(0, 16'h3F00, 16'h4000, 16'h4000, 3'd0, 1);
    ord_q = '{0};
    drain("t1");

    // Test 2: three simultaneous requesters, served 1,2,3 five cycles apart.
    set_req(1, 16'h4000, 16'h4000, 16'h4100, 3'd0, 1);
    set_req(2, 16'h3F00, 16'h3F80, 16'h3F80, 3'd0, 1);
    set_req(3, 16'h4080, 16'h4000, 16'h4180, 3'd0, 1);
    ord_q = '{1, 2, 3};
    gap_chk = 1; prev_acc = -1;
    drain("t2");
    gap_chk = 0;

    // Test 3: status encodings.
    set_req(2, 16'h3F80, 16'h3F80, 16'h4020, 3'd0, 1); ord_q = '{2}; drain("t3_ok");
    set_req(0, 16'h7F01, 16'h3F00, 16'h7FFF, 3'd4, 1); ord_q = '{0}; drain("t3_nan");
    set_req(3, 16'h0000, 16'h4000, 16'h0000, 3'd3, 1); ord_q = '{3}; drain("t3_zero");
    set_req(1, 16'h7E00, 16'h4100, 16'h7F00, 3'd1, 1); ord_q = '{1}; drain("t3_ovf");
    set_req(3, 16'h0100, 16'h0100, 16'h0000, 3'd2, 1); ord_q = '{3}; drain("t3_unf");

    set_req(0, 16'h3F00, 16'h4000, 16'h4000, 3'd0, 0);
    set_req(1, 16'h4000, 16'h4000, 16'h4100, 3'd0, 0);
    set_req(2, 16'h3F00, 16'h3F80, 16'h3F80, 3'd0, 0);
    set_req(3, 16'h4080, 16'h4000, 16'h4180, 3'd0, 0);
`ifndef FP_SCHED_FIXED_PRI_EN
    // Test 4: all four held valid for 20 ops, strict rotation.
    for (int i = 0; i < N; i++) rem[i] = 5;
    for (int k = 0; k < 20; k++) ord_q.push_back(k % N);
    gap_chk = 1; prev_acc = -1;
    drain("t4");
    gap_chk = 0;
`else
    // Test 6: fixed priority, requester 3 starves while requester 0 stays valid.
    begin
      int k = 0;
      rem[0] = 6; rem[3] = 6;
      for (int j = 0; j < 6; j++) ord_q.push_back(0);
      while (rem[0] != 0 && k < 200) begin
        advance();
        if (rem[0] == 0) begin
          check("t6_req3_starved", 64'(rem[3]), 64'd6);
          rem[3] = 0;
          drive();
        end
        sample();
        k++;
      end
      drain("t6");
    end
`endif

    // Test 5: reset during WAIT aborts the op; req0 is accepted on the first idle cycle.
    set_req(0, 16'h3F80, 16'h3F80, 16'h4020, 3'd0, 1);
    ord_q = '{0};
    begin
      int k = 0;
      while (last_acc == 0 && k < 20) begin
        step();
        k++;
      end
      check("t5_accepted", 64'(last_acc), 64'd1);
    end
    advance();
    @(negedge clk);
    check("t5_busy_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    #1 check("t5_reset_outputs",
             64'({req_ready, rsp_valid, rsp_result, rsp_status, rsp_id, mul_x, mul_y, busy}),
             64'd0);
    sb_q.delete();
    ord_q.delete();
    last_acc = '0;
    set_req(0, 16'h4000, 16'h4080, 16'h4180, 3'd0, 1);
    drive();
    repeat (3) @(negedge clk);
    #1 check("t5_ready_in_reset", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ord_q = '{0};
    sample();
    check("t5_first_idle_accept", 64'(last_acc), 64'd1);
    drain("t5");
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
